and_16bit_bist: RTL

AND_16BIT_BIST -- requirements
Module: and_16bit_bist

---
 rtl/and_16bit_bist.sv | 116 +++++++++++
 1 files changed

// File: rtl/and_16bit_bist.sv
// Built-in self-test for a combinational 16-bit AND: it applies walking-one vectors and then LFSR vectors,
// and accumulates a saturating mismatch count and a sticky mask of failing result bits.
module and_16bit_bist #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dut_out,
    output logic [15:0] dut_a,
    output logic [15:0] dut_b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] fail_mask
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WALK = 2'd1;
    localparam logic [1:0] RAND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [16:0] WALK_LAST = 17'd31;
    localparam logic [16:0] RAND_LAST = 17'(NUM_VECTORS - 1);

    logic [1:0]  state;
    logic [16:0] vec_cnt;
    logic [15:0] lfsr_a;
    logic [15:0] lfsr_b;
    logic [15:0] mismatch;
    logic [4:0]  walk_next;

    // x^16+x^14+x^13+x^11+1, Fibonacci form, shifting toward the MSB
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign busy      = (state == WALK) || (state == RAND);
    assign done      = (state == DONE);
    assign pass      = done && (err_count == 8'd0);
    assign mismatch  = busy ? (dut_out ^ (dut_a & dut_b)) : '0;
    assign walk_next = vec_cnt[4:0] + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            vec_cnt   <= '0;
            lfsr_a    <= SEED;
            lfsr_b    <= ~SEED;
            dut_a     <= '0;
            dut_b     <= '0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            // Vector presented this cycle is scored at its closing edge, including the last one.
            if (mismatch != 16'h0000) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                fail_mask <= fail_mask | mismatch;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WALK;
                        vec_cnt   <= '0;
                        lfsr_a    <= SEED;
                        lfsr_b    <= ~SEED;
                        dut_a     <= 16'h0001;
                        dut_b     <= 16'hFFFF;
                        err_count <= '0;
                        fail_mask <= '0;
                    end
                end
                WALK: begin
                    if (vec_cnt == WALK_LAST) begin
                        // LFSR registers hold the next vector to present, so the seeds go out first.
                        state   <= RAND;
                        vec_cnt <= '0;
                        dut_a   <= lfsr_a;
                        dut_b   <= lfsr_b;
                        lfsr_a  <= lfsr_step(lfsr_a);
                        lfsr_b  <= lfsr_step(lfsr_b);
                    end else begin
                        vec_cnt <= vec_cnt + 17'd1;
                        if (!walk_next[4]) begin
                            dut_a <= 16'h0001 << walk_next[3:0];
                            dut_b <= 16'hFFFF;
                        end else begin
                            dut_a <= 16'hFFFF;
                            dut_b <= 16'h0001 << walk_next[3:0];
                        end
                    end
                end
                RAND: begin
                    if (vec_cnt == RAND_LAST) begin
                        state <= DONE;
                        dut_a <= '0;
                        dut_b <= '0;
                    end else begin
                        vec_cnt <= vec_cnt + 17'd1;
                        dut_a   <= lfsr_a;
                        dut_b   <= lfsr_b;
                        lfsr_a  <= lfsr_step(lfsr_a);
                        lfsr_b  <= lfsr_step(lfsr_b);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
